text_cmd_engine: RTL

TEXT_CMD_ENGINE -- requirements
Module: text_cmd_engine

---
 rtl/text_cmd_engine.sv | 270 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/text_cmd_engine.sv
// text_cmd_engine
//   Character-cell text display engine driven by a CPU command stream.
//   Every transfer is a command word followed by exactly one parameter word.
//   The character RAM is read by a display scanner through a registered port.
//
// Ports
//   clk        sole clock, rising edge
//   clr        synchronous active-high reset (RAM contents are kept)
//   cpuline    16-bit command/parameter word from the CPU
//   cpu_valid  cpuline holds a word
//   cpu_ready  engine accepts a word this cycle (word moves on valid & ready)
//   rd_addr    scanner address, row*COLS+col in screen (logical) coordinates
//   rd_data    character at rd_addr, one cycle later
//   cur_x      cursor column
//   cur_y      cursor row (logical)
//   busy       a multi-cycle clear is running
//
// Commands: C0/0 and C5 full clear, C1 write char, C2 backspace,
//           C3 set row, C4 set column, C6 newline; others are discarded.
//
// Build option: SCROLL_EN -- when defined, a line advance on the last row
// scrolls the screen up one row (ring-buffer top pointer) and blanks the new
// bottom row; when undefined the cursor wraps to row 0 and top stays 0.
//
// State table
//   state     | meaning
//   S_CMD     | waiting for a command word
//   S_PARAM   | waiting for the parameter word
//   S_EXEC    | single cycle: execute the decoded command
//   S_CLEAR   | blanking the whole RAM, one cell per cycle
//   S_CLRLINE | blanking the new bottom row after a scroll (SCROLL_EN only)

module text_cmd_engine #(
  parameter  int COLS = 40,
  parameter  int ROWS = 25,
  parameter  int CW   = 8,
  localparam int AW   = $clog2(COLS*ROWS),
  localparam int XW   = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int YW   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic          clk,
  input  logic          clr,
  input  logic [15:0]   cpuline,
  input  logic          cpu_valid,
  output logic          cpu_ready,
  input  logic [AW-1:0] rd_addr,
  output logic [CW-1:0] rd_data,
  output logic [XW-1:0] cur_x,
  output logic [YW-1:0] cur_y,
  output logic          busy
);

  localparam int N = COLS * ROWS;
  localparam logic [XW-1:0] X_LAST = XW'(COLS - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(ROWS - 1);

  localparam logic [15:0] C_CLR0  = 16'h00C0;
  localparam logic [15:0] C_PUT   = 16'h00C1;
  localparam logic [15:0] C_BKSP  = 16'h00C2;
  localparam logic [15:0] C_SETY  = 16'h00C3;
  localparam logic [15:0] C_SETX  = 16'h00C4;
  localparam logic [15:0] C_CLR   = 16'h00C5;
  localparam logic [15:0] C_NL    = 16'h00C6;

  typedef enum logic [2:0] {
    S_CMD, S_PARAM, S_EXEC, S_CLEAR
`ifdef SCROLL_EN
    , S_CLRLINE
`endif
  } state_t;

  state_t        state;
  logic [15:0]   cmd;
  logic [15:0]   param;
  logic [AW-1:0] cnt;        // down-counter for CLEAR / CLRLINE, done at 0
  logic [YW-1:0] top;        // physical row shown as logical row 0
`ifdef SCROLL_EN
  logic [AW-1:0] line_base;  // physical address of the row being blanked
`endif

  logic [CW-1:0] mem [N];

  logic          fire;
  logic          at_origin;
  logic          do_adv;
  logic [XW-1:0] bs_x, wx;
  logic [YW-1:0] bs_y, wy;
  logic [YW:0]   row_sum;
  logic [AW-1:0] cell_addr;
  logic [AW:0]   rd_sum;
  logic [AW-1:0] rd_phys;
  logic          we;
  logic [AW-1:0] waddr;
  logic [CW-1:0] wdata;

  assign fire      = cpu_valid && cpu_ready;
  assign at_origin = (cur_x == '0) && (cur_y == '0);
  assign do_adv    = (state == S_EXEC) &&
                     (((cmd == C_PUT) && (cur_x == X_LAST)) || (cmd == C_NL));
  assign bs_x      = (cur_x == '0) ? X_LAST : cur_x - XW'(1);
  assign bs_y      = (cur_x == '0) ? cur_y - YW'(1) : cur_y;

`ifndef SCROLL_EN
  assign top = '0;
`endif

  // Cursor cell in physical RAM; backspace targets the cell before the cursor.
  always_comb begin
    wx = cur_x;
    wy = cur_y;
    if (cmd == C_BKSP) begin
      wx = bs_x;
      wy = bs_y;
    end
    row_sum = {1'b0, top} + {1'b0, wy};
    if (row_sum >= (YW+1)'(ROWS)) row_sum = row_sum - (YW+1)'(ROWS);
    cell_addr = AW'(row_sum[YW-1:0]) * AW'(COLS) + AW'(wx);
  end

  // Scanner address rotated by the top row; one extra bit holds the sum
  // because top*COLS + rd_addr can reach up to 2*N-1.
  always_comb begin
    rd_sum = {1'b0, rd_addr} + (AW+1)'(top) * (AW+1)'(COLS);
    if (rd_sum >= (AW+1)'(N)) rd_sum = rd_sum - (AW+1)'(N);
    rd_phys = rd_sum[AW-1:0];
  end

  always_comb begin
    we    = 1'b0;
    waddr = '0;
    wdata = '0;
    case (state)
      S_EXEC: begin
        if (cmd == C_PUT) begin
          we    = 1'b1;
          waddr = cell_addr;
          wdata = param[CW-1:0];
        end else if ((cmd == C_BKSP) && !at_origin) begin
          we    = 1'b1;
          waddr = cell_addr;
        end
      end
      S_CLEAR: begin
        we    = 1'b1;
        waddr = cnt;
      end
`ifdef SCROLL_EN
      S_CLRLINE: begin
        we    = 1'b1;
        waddr = line_base + cnt;
      end
`endif
      default: ;
    endcase
    if (clr) we = 1'b0;
  end

  // RAM has no reset; clr must not disturb stored characters.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= S_CMD;
      cmd       <= '0;
      param     <= '0;
      cnt       <= '0;
      cur_x     <= '0;
      cur_y     <= '0;
      cpu_ready <= 1'b1;
      busy      <= 1'b0;
      rd_data   <= '0;
`ifdef SCROLL_EN
      top       <= '0;
      line_base <= '0;
`endif
    end else begin
      rd_data <= mem[rd_phys];
      case (state)
        S_CMD: begin
          if (fire) begin
            cmd   <= cpuline;
            state <= S_PARAM;
          end
        end
        S_PARAM: begin
          if (fire) begin
            param     <= cpuline;
            state     <= S_EXEC;
            cpu_ready <= 1'b0;
          end
        end
        S_EXEC: begin
          state     <= S_CMD;
          cpu_ready <= 1'b1;
          case (cmd)
            C_CLR0, C_CLR: begin
              if ((cmd == C_CLR) || (param == '0)) begin
                state     <= S_CLEAR;
                cpu_ready <= 1'b0;
                busy      <= 1'b1;
                cnt       <= AW'(N - 1);
              end
            end
            C_PUT:  cur_x <= (cur_x == X_LAST) ? '0 : cur_x + XW'(1);
            C_BKSP: begin
              if (!at_origin) begin
                cur_x <= bs_x;
                cur_y <= bs_y;
              end
            end
            C_SETY: cur_y <= (param > 16'(ROWS - 1)) ? Y_LAST : param[YW-1:0];
            C_SETX: cur_x <= (param > 16'(COLS - 1)) ? X_LAST : param[XW-1:0];
            C_NL:   cur_x <= '0;
            default: ;
          endcase
          if (do_adv) begin
            if (cur_y != Y_LAST) begin
              cur_y <= cur_y + YW'(1);
            end else begin
`ifdef SCROLL_EN
              // The old top row becomes the new bottom row and is blanked.
              top       <= (top == Y_LAST) ? '0 : top + YW'(1);
              line_base <= AW'(top) * AW'(COLS);
              cnt       <= AW'(COLS - 1);
              state     <= S_CLRLINE;
              cpu_ready <= 1'b0;
              busy      <= 1'b1;
`else
              cur_y <= '0;
`endif
            end
          end
        end
        S_CLEAR: begin
          if (cnt == '0) begin
            state     <= S_CMD;
            cpu_ready <= 1'b1;
            busy      <= 1'b0;
            cur_x     <= '0;
            cur_y     <= '0;
`ifdef SCROLL_EN
            top       <= '0;
`endif
          end else begin
            cnt <= cnt - AW'(1);
          end
        end
`ifdef SCROLL_EN
        S_CLRLINE: begin
          if (cnt == '0) begin
            state     <= S_CMD;
            cpu_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            cnt <= cnt - AW'(1);
          end
        end
`endif
        default: begin
          state     <= S_CMD;
          cpu_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
